// File: rtl/alu_pkg.sv
// Shared encodings for the operand loader and the comparison unit.
// Pure definitions; no logic, no latency.
package alu_pkg;

    typedef enum logic [1:0] {
        LOAD_X = 2'b00,
        LOAD_Y = 2'b01,
        VALID  = 2'b10
    } state_t;

    localparam logic [1:0] SEL_EQ  = 2'b00;
    localparam logic [1:0] SEL_LT  = 2'b01;
    localparam logic [1:0] SEL_GT  = 2'b10;
    localparam logic [1:0] SEL_MAX = 2'b11;

    localparam int OPERAND_W = 4;

endpackage

// File: rtl/button_debounce.sv
// Synchronise, debounce and rising-edge detect one raw push-button.
// Latency raw edge -> rise_pulse: 2 sync + DEBOUNCE_CYCLES clocks; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    // Built only from flops, so the pulse is glitch-free and one cycle wide.
    assign rise_pulse = level_q & ~prev_q;

endmodule

// File: rtl/comparison_operand_loader.sv
// Sequences X then Y+select from switches on button presses; holds them valid until acked.
// Captures one clock after load_pulse; consumer holds off via result_ack, presses in VALID are dropped.
module comparison_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_btn,
    input  logic             clear,
    input  logic [3:0]       sw_data,
    input  logic [1:0]       sw_sel,
    input  logic             result_ack,
    output logic [3:0]       x,
    output logic [3:0]       y,
    output logic [1:0]       select,
    output logic             operands_valid,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] pair_count
);

    logic load_pulse;
    logic btn_level_unused;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_btn (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw   (load_btn),
        .level     (btn_level_unused),
        .rise_pulse(load_pulse)
    );

    state_t                 state_q, state_d;
    logic [OPERAND_W-1:0]   x_q, x_d, y_q, y_d;
    logic [1:0]             sel_q, sel_d;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        // clear wins over any capture or ack in the same cycle.
        if (clear) begin
            state_d = LOAD_X;
            x_d     = '0;
            y_d     = '0;
            sel_d   = SEL_EQ;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_X: begin
                    if (load_pulse) begin
                        x_d     = sw_data;
                        state_d = LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    if (load_pulse) begin
                        y_d     = sw_data;
                        sel_d   = sw_sel;
                        valid_d = 1'b1;
                        state_d = VALID;
                    end
                end
                VALID: begin
                    if (result_ack) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = LOAD_X;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = LOAD_X;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOAD_X;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= SEL_EQ;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x              = x_q;
    assign y              = y_q;
    assign select         = sel_q;
    assign operands_valid = valid_q;
    assign state_out      = state_q;
    assign pair_count     = cnt_q;

endmodule

// File: tb/tb_comparison_operand_loader.sv
module tb_comparison_operand_loader;

    logic       clk;
    logic       resetn;
    logic       load_btn;
    logic       clear;
    logic [3:0] sw_data;
    logic [1:0] sw_sel;
    logic       result_ack;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] select;
    logic       operands_valid;
    logic [1:0] state_out;
    logic [7:0] pair_count;

    comparison_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .load_btn      (load_btn),
        .clear         (clear),
        .sw_data       (sw_data),
        .sw_sel        (sw_sel),
        .result_ack    (result_ack),
        .x             (x),
        .y             (y),
        .select        (select),
        .operands_valid(operands_valid),
        .state_out     (state_out),
        .pair_count    (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] sel;
    } pair_t;

    pair_t      exp_q[$];
    int         n_checks;
    int         n_err;
    logic [7:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic press(input logic [3:0] d, input logic [1:0] s, input int hold);
        sw_data  = d;
        sw_sel   = s;
        load_btn = 1'b1;
        repeat (hold) @(negedge clk);
        load_btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ack_pulse();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for operands_valid, then pops the expected pair and compares.
    task automatic check_valid(input string tag);
        pair_t e;
        int    waited;
        waited = 0;
        while (operands_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(operands_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_x"},     32'(x),         32'(e.x));
            chk({tag, "_y"},     32'(y),         32'(e.y));
            chk({tag, "_sel"},   32'(select),    32'(e.sel));
            chk({tag, "_state"}, 32'(state_out), 32'd2);
        end
    endtask

    task automatic load_pair(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                             input logic [1:0] sv);
        press(xv, 2'b00, 8);
        exp_q.push_back('{x: xv, y: yv, sel: sv});
        press(yv, sv, 8);
        check_valid(tag);
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        exp_cnt    = 8'd0;
        resetn     = 1'b0;
        load_btn   = 1'b0;
        clear      = 1'b0;
        sw_data    = 4'd0;
        sw_sel     = 2'd0;
        result_ack = 1'b0;

        #3;
        chk("rst_x",     32'(x),              32'd0);
        chk("rst_valid", 32'(operands_valid), 32'd0);
        chk("rst_state", 32'(state_out),      32'd0);
        chk("rst_cnt",   32'(pair_count),     32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // First press: capture lands on the 7th rising edge after the raw edge.
        sw_data  = 4'b0101;
        load_btn = 1'b1;
        repeat (6) @(negedge clk);
        chk("lat_before", 32'(state_out), 32'd0);
        @(negedge clk);
        chk("lat_state", 32'(state_out), 32'd1);
        chk("lat_x",     32'(x),         32'd5);
        repeat (3) @(negedge clk);
        load_btn = 1'b0;
        repeat (8) @(negedge clk);

        ack_pulse();
        chk("ack_ly_state", 32'(state_out),  32'd1);
        chk("ack_ly_cnt",   32'(pair_count), 32'd0);

        exp_q.push_back('{x: 4'b0101, y: 4'b0011, sel: 2'b11});
        press(4'b0011, 2'b11, 8);
        check_valid("pair1");

        press(4'b1111, 2'b00, 8);
        chk("vpress_y",     32'(y),              32'd3);
        chk("vpress_valid", 32'(operands_valid), 32'd1);
        chk("vpress_state", 32'(state_out),      32'd2);

        ack_pulse();
        exp_cnt++;
        chk("ack_state", 32'(state_out),      32'd0);
        chk("ack_valid", 32'(operands_valid), 32'd0);
        chk("ack_cnt",   32'(pair_count),     32'(exp_cnt));
        chk("ack_xkeep", 32'(x),              32'd5);

        press(4'b1000, 2'b00, 3);
        chk("glitch3_state", 32'(state_out), 32'd0);
        chk("glitch3_x",     32'(x),         32'd5);
        press(4'b1001, 2'b00, 4);
        chk("glitch4_state", 32'(state_out), 32'd1);
        chk("glitch4_x",     32'(x),         32'd9);
        exp_q.push_back('{x: 4'b1001, y: 4'b0110, sel: 2'b01});
        press(4'b0110, 2'b01, 8);
        check_valid("pair2");
        ack_pulse();
        exp_cnt++;

        press(4'b0111, 2'b00, 100);
        chk("hold_state", 32'(state_out), 32'd1);
        chk("hold_x",     32'(x),         32'd7);
        exp_q.push_back('{x: 4'b0111, y: 4'b0010, sel: 2'b10});
        press(4'b0010, 2'b10, 8);
        check_valid("pair3");

        clear      = 1'b1;
        result_ack = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        result_ack = 1'b0;
        chk("clr_state", 32'(state_out),      32'd0);
        chk("clr_x",     32'(x),              32'd0);
        chk("clr_y",     32'(y),              32'd0);
        chk("clr_sel",   32'(select),         32'd0);
        chk("clr_valid", 32'(operands_valid), 32'd0);
        chk("clr_cnt",   32'(pair_count),     32'(exp_cnt));

        while (exp_cnt != 8'd255) begin
            load_pair("wrap_pair", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)));
            ack_pulse();
            exp_cnt++;
        end
        chk("wrap_255", 32'(pair_count), 32'd255);
        load_pair("wrap_last", 4'd12, 4'd4, 2'b00);
        ack_pulse();
        exp_cnt++;
        chk("wrap_0", 32'(pair_count), 32'(exp_cnt));

        load_pair("pre_rst", 4'd9, 4'd1, 2'b10);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_x",     32'(x),              32'd0);
        chk("arst_y",     32'(y),              32'd0);
        chk("arst_valid", 32'(operands_valid), 32'd0);
        chk("arst_state", 32'(state_out),      32'd0);
        chk("arst_cnt",   32'(pair_count),     32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
